// File: rtl/floors.sv
// Elevator call-button latch: rising-edge press detection on cabin, hall-up and hall-down buttons.
// Define FLOORS_CANCEL_EN to let a second press on a lit button cancel it (toggle).
module floors #(
    parameter int BUTTONS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    output logic [BUTTONS_WIDTH-1:0] active_in_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_down_levels
);

    // Top floor has no "up" call and bottom floor has no "down" call.
    localparam logic [BUTTONS_WIDTH-1:0] UP_MASK   = {1'b0, {(BUTTONS_WIDTH-1){1'b1}}};
    localparam logic [BUTTONS_WIDTH-1:0] DOWN_MASK = {{(BUTTONS_WIDTH-1){1'b1}}, 1'b0};

    logic [BUTTONS_WIDTH-1:0] num_prev_q, up_prev_q, down_prev_q;
    logic [BUTTONS_WIDTH-1:0] in_lvl_q, up_lvl_q, down_lvl_q;
    logic [BUTTONS_WIDTH-1:0] in_lvl_d, up_lvl_d, down_lvl_d;
    logic [BUTTONS_WIDTH-1:0] num_press, up_press, down_press;

    always_comb begin
        num_press  = btn_num_in   & ~num_prev_q;
        up_press   = btn_up_out   & ~up_prev_q;
        down_press = btn_down_out & ~down_prev_q;
`ifdef FLOORS_CANCEL_EN
        in_lvl_d   = in_lvl_q ^ num_press;
        up_lvl_d   = (up_lvl_q ^ up_press) & UP_MASK;
        down_lvl_d = (down_lvl_q ^ down_press) & DOWN_MASK;
`else
        in_lvl_d   = in_lvl_q | num_press;
        up_lvl_d   = (up_lvl_q | up_press) & UP_MASK;
        down_lvl_d = (down_lvl_q | down_press) & DOWN_MASK;
`endif
    end

    // Previous samples clear on reset so a button held across reset release counts as a new press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_prev_q  <= '0;
            up_prev_q   <= '0;
            down_prev_q <= '0;
            in_lvl_q    <= '0;
            up_lvl_q    <= '0;
            down_lvl_q  <= '0;
        end else begin
            num_prev_q  <= btn_num_in;
            up_prev_q   <= btn_up_out;
            down_prev_q <= btn_down_out;
            in_lvl_q    <= in_lvl_d;
            up_lvl_q    <= up_lvl_d;
            down_lvl_q  <= down_lvl_d;
        end
    end

    assign active_in_levels       = in_lvl_q;
    assign active_out_up_levels   = up_lvl_q;
    assign active_out_down_levels = down_lvl_q;

endmodule

// File: tb/tb_floors.sv
// Scoreboard bench for floors: driver pushes expected outputs, monitor compares after each edge.
module tb_floors;
    localparam int W  = 8;
    localparam int EW = 3 * W;

`ifdef FLOORS_CANCEL_EN
    localparam logic [W-1:0] IN_REPRESS = 8'h0A;
`else
    localparam logic [W-1:0] IN_REPRESS = 8'h0E;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] btn_num_in = '0;
    logic [W-1:0] btn_up_out = '0;
    logic [W-1:0] btn_down_out = '0;
    logic [W-1:0] active_in_levels, active_out_up_levels, active_out_down_levels;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_v;
    int checks = 0;
    int errors = 0;

    floors #(.BUTTONS_WIDTH(W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .btn_num_in            (btn_num_in),
        .btn_up_out            (btn_up_out),
        .btn_down_out          (btn_down_out),
        .active_in_levels      (active_in_levels),
        .active_out_up_levels  (active_out_up_levels),
        .active_out_down_levels(active_out_down_levels)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in"}, active_in_levels, 8'h00);
        check({tag, "_up"}, active_out_up_levels, 8'h00);
        check({tag, "_dn"}, active_out_down_levels, 8'h00);
    endtask

    // Drive one cycle of buttons; expected outputs apply after the following rising edge.
    task automatic step(input logic [W-1:0] n, input logic [W-1:0] u, input logic [W-1:0] d,
                        input logic [W-1:0] ei, input logic [W-1:0] eu, input logic [W-1:0] ed);
        @(negedge clk);
        btn_num_in   = n;
        btn_up_out   = u;
        btn_down_out = d;
        exp_q.push_back({ei, eu, ed});
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("mon_in", active_in_levels,       exp_v[3*W-1:2*W]);
            check("mon_up", active_out_up_levels,   exp_v[2*W-1:W]);
            check("mon_dn", active_out_down_levels, exp_v[W-1:0]);
        end
    end

    initial begin
        #2 reset = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b1;

        // single-cycle hall-up press latches and survives release
        step(8'h00, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00);

        // simultaneous events on all three vectors
        step(8'h02, 8'h20, 8'h80, 8'h02, 8'h30, 8'h80);
        step(8'h00, 8'h00, 8'h00, 8'h02, 8'h30, 8'h80);

        // masked top-floor up and bottom-floor down
        step(8'h00, 8'h80, 8'h01, 8'h02, 8'h30, 8'h80);
        step(8'h00, 8'h80, 8'h01, 8'h02, 8'h30, 8'h80);
        step(8'h00, 8'h00, 8'h00, 8'h02, 8'h30, 8'h80);

        // held button: exactly one press event
        for (int i = 0; i < 10; i++)
            step(8'h08, 8'h00, 8'h00, 8'h0A, 8'h30, 8'h80);
        step(8'h00, 8'h00, 8'h00, 8'h0A, 8'h30, 8'h80);

        // press, release, press again
        step(8'h04, 8'h00, 8'h00, 8'h0E, 8'h30, 8'h80);
        step(8'h00, 8'h00, 8'h00, 8'h0E, 8'h30, 8'h80);
        step(8'h04, 8'h00, 8'h00, IN_REPRESS, 8'h30, 8'h80);
        step(8'h00, 8'h00, 8'h00, IN_REPRESS, 8'h30, 8'h80);

        // multi-bit press on fresh bits of every vector
        step(8'h41, 8'h03, 8'h06, IN_REPRESS | 8'h41, 8'h33, 8'h86);
        step(8'h00, 8'h00, 8'h00, IN_REPRESS | 8'h41, 8'h33, 8'h86);

        // reset between edges while down[6] is held, then release
        @(negedge clk);
        btn_down_out = 8'h40;
        #2 reset = 1'b0;
        #1 check_all_zero("reset_midop");
        repeat (3) @(negedge clk);
        check_all_zero("reset_midop_held");
        reset = 1'b1;
        exp_q.push_back({8'h00, 8'h00, 8'h40});
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
